dds_pwm_dac: RTL and testbench
==============================

// Module: dds_pwm_dac
// PURPOSE
//  Downstream output stage of the DDS. Consumes the DDS 8-bit sine sample and
//  converts it into a single-bit PWM stream, which drives an external RC
//  low-pass filter to form an analog DAC. It latches one sample per PWM period
//  and pulses sample_req so the DDS/debug logic can align. Supports graceful
//  stop (finish the current period) and immediate abort.
// PARAMETERS
//  DATA_WIDTH  8  sample width; the PWM period is 2**DATA_WIDTH ticks
//  CLK_DIV     1  clocks per PWM tick (>=1); 1 = tick every clk
// PORTS
//  clk         in   1           system clock, rising edge
//  reset       in   1           asynchronous, active-low reset
//  enable      in   1           1 = run; 0 = immediate abort to IDLE
//  stop        in   1           graceful stop request, sampled each clk
//  sample      in   DATA_WIDTH  unsigned offset-binary sample (DDS out)
//  sample_req  out  1           1-clk pulse on the clk that sample is latched
//  pwm_out     out  1           registered PWM output
//  busy        out  1           1 in RUN or DRAIN
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, pwm_out=0, sample_req=0, busy=0,
//    cnt=0, duty=0, prescaler=0.
//  - tick: prescaler counts 0..CLK_DIV-1. tick=1 on the last count; it is
//    always 1 when CLK_DIV=1. The prescaler is held at 0 in IDLE.
//  - cnt: a DATA_WIDTH-bit period counter. It advances on tick and wraps
//    2**DATA_WIDTH-1 -> 0 (natural overflow).
//  - Period start = tick && cnt==0. At period start: duty<=sample and
//    sample_req=1 for exactly that clk.
//  - pwm_out <= (cnt < duty), registered, so it has 1 clk latency from cnt.
//    duty=0 gives constant 0. duty=2**DATA_WIDTH-1 gives high for 255 of 256
//    ticks (DATA_WIDTH=8).
//  - FSM states: IDLE, RUN, DRAIN.
//    IDLE->RUN when enable=1 && stop=0. On entry, cnt=0 and the first tick
//      is a period start.
//    RUN->DRAIN when stop=1, unless stop arrives on the last tick of a
//      period (cnt=max && tick). In that case go RUN->IDLE directly.
//    DRAIN: no new sample is latched. When the last tick of the period
//      (cnt=max && tick) is reached, go to IDLE.
//      Deasserting stop in DRAIN does not return to RUN.
//    any->IDLE on the next clk when enable=0. enable=0 takes priority over
//      stop and over the period boundary.
//  - IDLE outputs: pwm_out=0, busy=0, sample_req=0. cnt and prescaler are
//    cleared. duty is held.
//  - Async reset mid-period: all outputs drop on the reset edge, not at clk.
//    There is no partial-period output after release.
//  - enable=1 && stop=1 in IDLE: remain in IDLE.
//  - sample is only sampled at period start. Changes at other times are
//    ignored.
// STRUCTURE
//  - Shared header dds_defs.vh holds the FSM state encodings
//    (IDLE=2'b00, RUN=2'b01, DRAIN=2'b10) and DDS_DATA_WIDTH=8. That header
//    is shared with the DDS controller.
//  - Sub-module pwm_prescaler(clk, reset, clr, tick), parameterised by
//    CLK_DIV. clr is asserted whenever the FSM is in IDLE.
//  - Top level contains the FSM, the period counter, the duty register and
//    the compare/output register.
// TESTING
//  1. Assert reset=0 mid-run at cnt=100 -> pwm_out, busy and sample_req are 0
//     immediately. After release the block is in IDLE.
//  2. CLK_DIV=1, sample=8'h80, enable=1 -> sample_req every 256 clks.
//     pwm_out high for 128 clks per period, starting 1 clk after period start.
//  3. Run sample=8'h00 and then 8'hFF, each held for 2 periods -> 0 clks high,
//     then 255 of 256 high. sample_req count = 4.
//  4. stop=1 at cnt=50 -> DRAIN. pwm_out keeps the current duty until
//     cnt=255. Next clk: IDLE, busy=0, and no extra sample_req.
//  5. enable=0 at cnt=50 with stop=1 the same clk -> IDLE on the next clk,
//     with no drain.
//  6. CLK_DIV=4, sample=8'h40 -> period = 1024 clks and high time = 256 clks.
//     Stream the DDS sine ROM at dds_word=1 and check that the sample_req
//     cadence matches.

Source files
------------

// File: rtl/dds_pwm_dac_pkg.sv
// +--------------------------------------------------------------------------+
// | dds_pwm_dac_pkg : shared DDS sample width and PWM output-stage states     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package dds_pwm_dac_pkg;

  localparam int DDS_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } pwm_state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_prescaler.sv
// +--------------------------------------------------------------------------+
// | pwm_prescaler : divides clk into one PWM tick every CLK_DIV clocks        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module pwm_prescaler
  import dds_pwm_dac_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] r_pcnt;
  logic             w_last;

  // With CLK_DIV=1 the counter never leaves 0, so tick is permanently high.
  assign w_last = (r_pcnt == CNT_W'(CLK_DIV - 1));
  assign tick   = w_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pcnt <= '0;
    end else if (clr || w_last) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dds_pwm_dac.sv
// +--------------------------------------------------------------------------+
// | dds_pwm_dac : DDS sample to single-bit PWM stream, one sample per period  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module dds_pwm_dac
  import dds_pwm_dac_pkg::*;
#(
  parameter int DATA_WIDTH = DDS_DATA_WIDTH,
  parameter int CLK_DIV    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  stop,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic                  sample_req,
  output logic                  pwm_out,
  output logic                  busy
);

  pwm_state_t            r_state;
  pwm_state_t            w_next_state;
  logic [DATA_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_duty;
  logic [DATA_WIDTH-1:0] w_duty_eff;
  logic                  r_pwm;
  logic                  w_tick;
  logic                  w_clr;
  logic                  w_last_tick;
  logic                  w_period_start;

  assign w_clr = (r_state == ST_IDLE);

  pwm_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (w_clr),
    .tick (w_tick)
  );

  assign w_last_tick    = w_tick && (r_cnt == '1);
  // An abort on a period boundary wins: no sample is requested or latched.
  assign w_period_start = (r_state == ST_RUN) && enable && w_tick && (r_cnt == '0);
  // Compare against the sample being latched so the first slot of a period
  // already uses the new duty.
  assign w_duty_eff     = w_period_start ? sample : r_duty;

  always_comb begin
    w_next_state = r_state;
    if (!enable) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (!stop) w_next_state = ST_RUN;
        ST_RUN:   if (stop) w_next_state = w_last_tick ? ST_IDLE : ST_DRAIN;
        ST_DRAIN: if (w_last_tick) w_next_state = ST_IDLE;
        default:  w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_pwm  <= 1'b0;
    end else begin
      if (w_period_start) begin
        r_duty <= sample;
      end
      if (w_next_state == ST_IDLE) begin
        r_cnt <= '0;
        r_pwm <= 1'b0;
      end else if ((r_state != ST_IDLE) && w_tick) begin
        r_cnt <= r_cnt + 1'b1;
        r_pwm <= (r_cnt < w_duty_eff);
      end
    end
  end

  assign sample_req = w_period_start;
  assign pwm_out    = r_pwm;
  assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dds_pwm_dac.sv
// +--------------------------------------------------------------------------+
// | tb_dds_pwm_dac : two DUTs (CLK_DIV=1 and 4) against a period-level model  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dds_pwm_dac;

  localparam int FAR = 1000000000;

  logic       clk_tb = 1'b0;
  logic       reset;
  logic       enable;
  logic       stop;
  logic [7:0] sample;
  logic [1:0] req;
  logic [1:0] pwm;
  logic [1:0] bsy;

  always #5 clk_tb = ~clk_tb;

  dds_pwm_dac #(.DATA_WIDTH(8), .CLK_DIV(1)) u_dut_div1 (
    .clk(clk_tb), .reset(reset), .enable(enable), .stop(stop), .sample(sample),
    .sample_req(req[0]), .pwm_out(pwm[0]), .busy(bsy[0])
  );

  dds_pwm_dac #(.DATA_WIDTH(8), .CLK_DIV(4)) u_dut_div4 (
    .clk(clk_tb), .reset(reset), .enable(enable), .stop(stop), .sample(sample),
    .sample_req(req[1]), .pwm_out(pwm[1]), .busy(bsy[1])
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  int         m_start = FAR;
  int         m_req_lim = FAR;
  int         m_end [2];
  logic [7:0] m_duty [2][16];

  // Model: a run starts in the clk where enable rises (rel=0). Ticks land at
  // rel = d*(j+1); tick j has period position j%256. The output seen in a
  // clk reflects the tick before it. A run ends at m_end (stop: the first
  // period end at or after the stop, abort: the abort clk).
  function automatic int dv(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic bit e_busy(int i, int rel);
    return (rel >= 1) && (rel <= m_end[i]);
  endfunction

  function automatic bit e_req(int i, int rel);
    int d = dv(i);
    if (rel < d || rel > m_end[i] || rel >= m_req_lim) return 1'b0;
    return ((rel - d) % (256 * d)) == 0;
  endfunction

  function automatic bit e_pwm(int i, int rel);
    int d = dv(i);
    int j;
    if (rel < d + 1 || rel > m_end[i]) return 1'b0;
    j = (rel - d - 1) / d;
    return (j % 256) < int'(m_duty[i][(j / 256) % 16]);
  endfunction

  function automatic int stop_end(int i, int t);
    int p = 256 * dv(i);
    return ((t + p - 1) / p) * p;
  endfunction

  function automatic logic [7:0] sine_rom(int ph);
    real a;
    a = 128.0 + 127.0 * $sin(6.283185307179586 * real'(ph) / 256.0);
    return 8'($rtoi(a));
  endfunction

  task automatic capture();
    int rel = cyc - m_start;
    for (int i = 0; i < 2; i++) begin
      if (e_req(i, rel)) m_duty[i][((rel - dv(i)) / (256 * dv(i))) % 16] = sample;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_tb);
    #1;
    cyc++;
  endtask

  task automatic start_run();
    enable    = 1'b1;
    stop      = 1'b0;
    m_start   = cyc;
    m_end     = '{FAR, FAR};
    m_req_lim = FAR;
  endtask

  task automatic apply_stop();
    int t = cyc - m_start;
    stop = 1'b1;
    for (int i = 0; i < 2; i++) m_end[i] = stop_end(i, t);
  endtask

  task automatic apply_abort();
    int t = cyc - m_start;
    enable    = 1'b0;
    stop      = 1'b1;
    m_end     = '{t, t};
    m_req_lim = t;
  endtask

  task automatic go_idle();
    enable  = 1'b0;
    stop    = 1'b0;
    m_start = FAR;
    repeat (2) next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; stop = 1'b0; sample = 8'hA5;
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({req[i], pwm[i], bsy[i]} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_async div%0d {req,pwm,busy} got %b%b%b want 000", dv(i), req[i], pwm[i], bsy[i]);
      end
    end
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({req[i], pwm[i], bsy[i]} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_held div%0d {req,pwm,busy} got %b%b%b want 000", dv(i), req[i], pwm[i], bsy[i]);
      end
    end
    reset = 1'b1; cyc = 0; m_start = FAR; m_end = '{FAR, FAR};
    stop = 1'b1;
    for (int r = 0; r < 6; r++) begin
      capture();
      @(negedge clk_tb);
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if ({req[i], pwm[i], bsy[i]} !== 3'b000) begin
          n_err++;
          $display("FAIL idle_enable_stop div%0d cyc=%0d got %b%b%b want 000", dv(i), cyc, req[i], pwm[i], bsy[i]);
        end
      end
      next_cycle();
    end
    go_idle();
  endtask

  task automatic test_half_duty();
    int hi = 0;
    int nreq = 0;
    start_run();
    sample = 8'h80;
    for (int r = 0; r <= 524; r++) begin
      int rel;
      if (r == 520) apply_abort();
      capture();
      @(negedge clk_tb);
      rel = cyc - m_start;
      if (rel >= 2 && rel <= 257 && pwm[0]) hi++;
      if (req[0]) nreq++;
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if ({req[i], pwm[i], bsy[i]} !== {e_req(i, rel), e_pwm(i, rel), e_busy(i, rel)}) begin
          n_err++;
          $display("FAIL half_duty div%0d rel=%0d {req,pwm,busy} got %b%b%b want %b%b%b", dv(i), rel,
                   req[i], pwm[i], bsy[i], e_req(i, rel), e_pwm(i, rel), e_busy(i, rel));
        end
      end
      next_cycle();
    end
    n_vec++;
    if (hi !== 128) begin n_err++; $display("FAIL half_high_time got %0d want 128", hi); end
    n_vec++;
    if (nreq !== 3) begin n_err++; $display("FAIL half_req_count got %0d want 3", nreq); end
    go_idle();
  endtask

  task automatic test_extremes();
    int hi0 = 0;
    int hiff = 0;
    int nreq = 0;
    start_run();
    for (int r = 0; r <= 1030; r++) begin
      int rel;
      sample = (r <= 257) ? 8'h00 : 8'hFF;
      if (r == 1024) apply_abort();
      capture();
      @(negedge clk_tb);
      rel = cyc - m_start;
      if (rel >= 2 && rel <= 513 && pwm[0]) hi0++;
      if (rel >= 514 && rel <= 769 && pwm[0]) hiff++;
      if (req[0]) nreq++;
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if ({req[i], pwm[i], bsy[i]} !== {e_req(i, rel), e_pwm(i, rel), e_busy(i, rel)}) begin
          n_err++;
          $display("FAIL extremes div%0d rel=%0d {req,pwm,busy} got %b%b%b want %b%b%b", dv(i), rel,
                   req[i], pwm[i], bsy[i], e_req(i, rel), e_pwm(i, rel), e_busy(i, rel));
        end
      end
      next_cycle();
    end
    n_vec++;
    if (hi0 !== 0) begin n_err++; $display("FAIL duty00_high got %0d want 0", hi0); end
    n_vec++;
    if (hiff !== 255) begin n_err++; $display("FAIL dutyFF_high got %0d want 255", hiff); end
    n_vec++;
    if (nreq !== 4) begin n_err++; $display("FAIL extremes_req_count got %0d want 4", nreq); end
    go_idle();
  endtask

  // Stop is pulsed at t, dropped for three clks mid-drain, then held so the
  // block stays in IDLE once both DUTs have drained.
  task automatic run_stop(string name, int t, bit pulse, bit rnd);
    int last;
    int late_req = 0;
    start_run();
    last = stop_end(1, t) + 6;
    for (int r = 0; r <= last; r++) begin
      int rel;
      sample = rnd ? 8'($urandom) : 8'hC3;
      if (r == t) apply_stop();
      else if (pulse && r > t && r <= t + 3) stop = 1'b0;
      else if (r > t) stop = 1'b1;
      capture();
      @(negedge clk_tb);
      rel = cyc - m_start;
      if (rel > t && req[0]) late_req++;
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if ({req[i], pwm[i], bsy[i]} !== {e_req(i, rel), e_pwm(i, rel), e_busy(i, rel)}) begin
          n_err++;
          $display("FAIL %s div%0d t=%0d rel=%0d {req,pwm,busy} got %b%b%b want %b%b%b", name, dv(i), t, rel,
                   req[i], pwm[i], bsy[i], e_req(i, rel), e_pwm(i, rel), e_busy(i, rel));
        end
      end
      next_cycle();
    end
    n_vec++;
    if (late_req !== 0) begin n_err++; $display("FAIL %s_req_after_stop got %0d want 0", name, late_req); end
    go_idle();
  endtask

  task automatic test_stop();
    run_stop("stop_cnt50", 51, 1'b1, 1'b1);
  endtask

  task automatic test_stop_last();
    run_stop("stop_last_tick", 256, 1'b0, 1'b0);
  endtask

  task automatic test_random_stop();
    for (int k = 0; k < 2; k++) begin
      run_stop("stop_random", 256 * int'($urandom_range(0, 2)) + int'($urandom_range(1, 200)), 1'b1, 1'b1);
    end
  endtask

  task automatic test_abort();
    start_run();
    sample = 8'h55;
    for (int r = 0; r <= 60; r++) begin
      int rel;
      if (r == 51) apply_abort();
      capture();
      @(negedge clk_tb);
      rel = cyc - m_start;
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if ({req[i], pwm[i], bsy[i]} !== {e_req(i, rel), e_pwm(i, rel), e_busy(i, rel)}) begin
          n_err++;
          $display("FAIL abort div%0d rel=%0d {req,pwm,busy} got %b%b%b want %b%b%b", dv(i), rel,
                   req[i], pwm[i], bsy[i], e_req(i, rel), e_pwm(i, rel), e_busy(i, rel));
        end
      end
      next_cycle();
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    int rel;
    start_run();
    for (int r = 0; r <= 100; r++) begin
      sample = 8'($urandom);
      capture();
      @(negedge clk_tb);
      rel = cyc - m_start;
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if ({req[i], pwm[i], bsy[i]} !== {e_req(i, rel), e_pwm(i, rel), e_busy(i, rel)}) begin
          n_err++;
          $display("FAIL pre_reset div%0d rel=%0d got %b%b%b want %b%b%b", dv(i), rel,
                   req[i], pwm[i], bsy[i], e_req(i, rel), e_pwm(i, rel), e_busy(i, rel));
        end
      end
      next_cycle();
    end
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({req[i], pwm[i], bsy[i]} !== 3'b000) begin
        n_err++;
        $display("FAIL async_reset_drop div%0d got %b%b%b want 000", dv(i), req[i], pwm[i], bsy[i]);
      end
    end
    enable = 1'b0; m_start = FAR;
    @(negedge clk_tb);
    next_cycle();
    reset = 1'b1;
    for (int r = 0; r < 5; r++) begin
      @(negedge clk_tb);
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if ({req[i], pwm[i], bsy[i]} !== 3'b000) begin
          n_err++;
          $display("FAIL post_reset_idle div%0d got %b%b%b want 000", dv(i), req[i], pwm[i], bsy[i]);
        end
      end
      next_cycle();
    end
    start_run();
    for (int r = 0; r <= 304; r++) begin
      sample = 8'($urandom);
      if (r == 300) apply_abort();
      capture();
      @(negedge clk_tb);
      rel = cyc - m_start;
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if ({req[i], pwm[i], bsy[i]} !== {e_req(i, rel), e_pwm(i, rel), e_busy(i, rel)}) begin
          n_err++;
          $display("FAIL post_reset_run div%0d rel=%0d got %b%b%b want %b%b%b", dv(i), rel,
                   req[i], pwm[i], bsy[i], e_req(i, rel), e_pwm(i, rel), e_busy(i, rel));
        end
      end
      next_cycle();
    end
    go_idle();
  endtask

  task automatic test_clkdiv4();
    int hi4 = 0;
    int nreq4 = 0;
    int last_req = -1;
    int ph = 0;
    start_run();
    for (int r = 0; r <= 2064; r++) begin
      int rel;
      sample = (r < 1000) ? 8'h40 : sine_rom(ph);
      ph = (ph + 1) % 256;
      if (r == 2060) apply_abort();
      capture();
      @(negedge clk_tb);
      rel = cyc - m_start;
      if (rel >= 5 && rel <= 1028 && pwm[1]) hi4++;
      if (req[1]) begin
        nreq4++;
        if (last_req >= 0) begin
          n_vec++;
          if (rel - last_req !== 1024) begin
            n_err++;
            $display("FAIL div4_req_cadence got %0d want 1024", rel - last_req);
          end
        end
        last_req = rel;
      end
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if ({req[i], pwm[i], bsy[i]} !== {e_req(i, rel), e_pwm(i, rel), e_busy(i, rel)}) begin
          n_err++;
          $display("FAIL clkdiv4_sine div%0d rel=%0d got %b%b%b want %b%b%b", dv(i), rel,
                   req[i], pwm[i], bsy[i], e_req(i, rel), e_pwm(i, rel), e_busy(i, rel));
        end
      end
      next_cycle();
    end
    n_vec++;
    if (hi4 !== 256) begin n_err++; $display("FAIL div4_high_time got %0d want 256", hi4); end
    n_vec++;
    if (nreq4 !== 3) begin n_err++; $display("FAIL div4_req_count got %0d want 3", nreq4); end
    go_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_half_duty();
    test_extremes();
    test_stop();
    test_stop_last();
    test_random_stop();
    test_abort();
    test_async_reset();
    test_clkdiv4();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
